// File: rtl/serial_op_control.sv
// Control unit for the bit-serial logic processor: turns debounced LoadA/LoadB/Execute
// levels into one-cycle load strobes and an exactly-N-cycle shift window.
module serial_op_control #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          LoadA,
  input  logic          LoadB,
  input  logic          Execute,
  output logic          Ld_A,
  output logic          Ld_B,
  output logic          Shift_En,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Count
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_n;
  logic          loada_q, loadb_q, armed;
  logic          rise_a, rise_b;
  logic [CW-1:0] count_n;
  logic          ld_a_n, ld_b_n, shift_n, done_n, busy_n;

  // armed blocks the first post-reset cycle so a level already high at release is not an edge
  assign rise_a = armed & LoadA & ~loada_q;
  assign rise_b = armed & LoadB & ~loadb_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      loada_q  <= 1'b0;
      loadb_q  <= 1'b0;
      armed    <= 1'b0;
      Count    <= '0;
      Ld_A     <= 1'b0;
      Ld_B     <= 1'b0;
      Shift_En <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_n;
      loada_q  <= LoadA;
      loadb_q  <= LoadB;
      armed    <= 1'b1;
      Count    <= count_n;
      Ld_A     <= ld_a_n;
      Ld_B     <= ld_b_n;
      Shift_En <= shift_n;
      Busy     <= busy_n;
      Done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = Count;
    ld_a_n  = 1'b0;
    ld_b_n  = 1'b0;
    shift_n = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        count_n = '0;
        if (Execute) begin
          state_n = SHIFT;
          shift_n = 1'b1;
        end else begin
          ld_a_n = rise_a;
          ld_b_n = rise_b;
        end
      end
      SHIFT: begin
        if (Count == LAST) begin
          state_n = HOLD;
          done_n  = 1'b1;
        end else begin
          count_n = Count + CW'(1);
          shift_n = 1'b1;
        end
      end
      HOLD: begin
        if (!Execute) begin
          state_n = IDLE;
          count_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_serial_op_control.sv
// Randomized self-checking bench for serial_op_control against an operation-level model.
module tb_serial_op_control;

  localparam int N  = 8;
  localparam int CW = $clog2(N);

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          LoadA = 1'b0, LoadB = 1'b0, Execute = 1'b0;
  logic          Ld_A, Ld_B, Shift_En, Busy, Done;
  logic [CW-1:0] Count;

  int tests_run = 0;
  int tests_failed = 0;

  // op < 0: idle; 0..N-1: index of the current shift; N: waiting for Execute release
  int op = -1;
  bit pa = 0, pb = 0, armed = 0;
  bit e_lda = 0, e_ldb = 0, e_done = 0;
  int shift_run = 0;

  always #5 Clk = ~Clk;

  serial_op_control #(.N(N)) u_dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .LoadA    (LoadA),
    .LoadB    (LoadB),
    .Execute  (Execute),
    .Ld_A     (Ld_A),
    .Ld_B     (Ld_B),
    .Shift_En (Shift_En),
    .Busy     (Busy),
    .Done     (Done),
    .Count    (Count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit a, input bit b, input bit e);
    e_lda  = 0;
    e_ldb  = 0;
    e_done = 0;
    if (op < 0) begin
      if (e) op = 0;
      else begin
        e_lda = armed && a && !pa;
        e_ldb = armed && b && !pb;
      end
    end else if (op < N - 1) begin
      op++;
    end else if (op == N - 1) begin
      op     = N;
      e_done = 1;
    end else if (!e) begin
      op = -1;
    end
    pa    = a;
    pb    = b;
    armed = 1;
  endtask

  task automatic compare_all();
    int exp_cnt;
    exp_cnt = (op < 0) ? 0 : ((op > N - 1) ? N - 1 : op);
    check("ld_a",     32'(Ld_A),     32'(e_lda));
    check("ld_b",     32'(Ld_B),     32'(e_ldb));
    check("shift_en", 32'(Shift_En), 32'((op >= 0 && op < N) ? 1 : 0));
    check("busy",     32'(Busy),     32'((op >= 0) ? 1 : 0));
    check("done",     32'(Done),     32'(e_done));
    check("count",    32'(Count),    32'(exp_cnt));
    if (Shift_En === 1'b1) shift_run++;
    if (Done === 1'b1) begin
      check("shifts_per_op", 32'(shift_run), 32'(N));
      shift_run = 0;
    end
  endtask

  // called just after a negedge; returns just after the next negedge
  task automatic step(input bit a, input bit b, input bit e);
    LoadA   = a;
    LoadB   = b;
    Execute = e;
    @(posedge Clk);
    model_edge(a, b, e);
    #1;
    compare_all();
    @(negedge Clk);
  endtask

  task automatic do_reset(input bit e_at_release);
    #2 Reset = 1'b0;
    #1;
    check("rst_ld_a",     32'(Ld_A),     32'(0));
    check("rst_ld_b",     32'(Ld_B),     32'(0));
    check("rst_shift_en", 32'(Shift_En), 32'(0));
    check("rst_busy",     32'(Busy),     32'(0));
    check("rst_done",     32'(Done),     32'(0));
    check("rst_count",    32'(Count),    32'(0));
    op = -1; pa = 0; pb = 0; armed = 0; shift_run = 0;
    e_lda = 0; e_ldb = 0; e_done = 0;
    @(posedge Clk);
    @(negedge Clk);
    Execute = e_at_release;
    Reset   = 1'b1;
  endtask

  initial begin
    bit a, b, e;
    int run_left;

    @(negedge Clk);
    do_reset(1'b0);

    // single LoadA pulse from a held level, then coincident LoadA/LoadB rise
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);

    // full operation with Execute held for 22 cycles
    for (int i = 0; i < 22; i++) step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // early release: HOLD lasts one cycle
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0);

    // LoadA rising with Execute, LoadB rising mid-shift and held past the op
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0);

    // re-trigger after 11 idle cycles
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    for (int i = 0; i < 11; i++) step(0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    step(0, 0, 0);

    // reset after three shift cycles, released with Execute high
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 0);

    // randomized traffic
    a = 0; b = 0; e = 0; run_left = 3;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) a = ~a;
      if ($urandom_range(0, 3) == 0) b = ~b;
      run_left--;
      if (run_left <= 0) begin
        e = ~e;
        run_left = $urandom_range(1, 25);
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset(e);
      end
      step(a, b, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
